fnd_scan_decoder: RTL
=====================

# fnd_scan_decoder

Receive-side counterpart of the 4-digit FND display path. It watches the multiplexed `fnd_digit`/`fnd_data` lines driven by the FND controller and reconstructs the displayed decimal value 0–9999 as a 14-bit binary word. It sits beside the display driver as a loopback/self-check monitor: its `o_value` can be compared against the counter value that fed the display.

## Interface
- `SETTLE_CYC`, default 16: number of consecutive cycles a digit/segment pair must hold unchanged before it is captured. Legal range 2..255.
- `clk`  in  1  system clock; every flop is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (clears the block while low).
- `fnd_digit`  in  4  digit select, active-low one-hot; bit0 = ones digit, bit3 = thousands.
- `fnd_data`  in  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.
- `o_value`  out  14  last successfully decoded frame, binary 0..9999.
- `o_valid`  out  1  one-cycle pulse when `o_value` updates.
- `o_err`  out  1  one-cycle pulse when a completed frame contained an undecodable digit.

## Operation
- Input stage: `fnd_digit` and `fnd_data` are registered once; all further logic uses the registered copies.
- Stability filter: an 8-bit counter increments while the registered pair equals the previous registered pair, and resets to 0 on any change.
- Capture rule: the pair is captured once, on the cycle the counter reaches `SETTLE_CYC`. It is not captured again until the pair changes.
- Digit-select validity: the pair is captured only if `fnd_digit` is exactly one of 4'b1110, 4'b1101, 4'b1011, 4'b0111. All-ones (blank) or multi-hot values are ignored.
- Segment decode: bit7 (dp) is masked. 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, bits[6:0] compared with bit7 forced 1).
- Bad segment patterns: any other pattern stores digit 0 for that slot and sets that slot's bad flag.
- Slot storage: a capture writes the 4-bit BCD digit plus bad flag into the slot selected by `fnd_digit`, and sets that slot's bit in a 4-bit collect mask.
- Re-capture: capturing a slot that is already set overwrites it; this is not an error.
- FSM states:
  - COLLECT: when the mask reaches 4'b1111, snapshot all slots into frame registers, clear the mask, go to CONVERT.
  - CONVERT: compute d3*1000 + d2*100 + d1*10 + d0 into a 14-bit register (intermediates are 14 bits; the maximum, 9999, fits). OR the bad flags together. Go to EMIT.
  - EMIT: if any bad flag is set, pulse `o_err` and hold `o_value`. Otherwise load `o_value` and pulse `o_valid`. Return to COLLECT.
- Captures continue to update slots and mask during CONVERT/EMIT. No capture is lost, because `SETTLE_CYC` ≥ 2.
- Reset (asserted at any time, including mid-frame): FSM goes to COLLECT; mask, slots, counter and input registers clear.

## Timing
- Reset values: `o_value`=0, `o_valid`=0, `o_err`=0.
- Capture latency: a pair that appears at the ports on edge N is captured on edge N+1+`SETTLE_CYC`.
- Output latency: `o_valid`/`o_err` assert 2 cycles after the capture edge that completes the mask, and are high for exactly 1 cycle. `o_value` changes on the same edge `o_valid` rises.
- `o_valid` and `o_err` are never high together.
- Minimum frame period: 4×(`SETTLE_CYC`+1) cycles when each digit is held just long enough.

## Configuration
- `FND_DECODE_CHANGE_ONLY_EN` defined: in EMIT, a good frame whose value equals the current `o_value` produces no `o_valid` pulse. The value is still reloaded (no visible change). `o_err` behaviour is unchanged.
- Macro undefined: every good frame pulses `o_valid`, even when the value repeats.

## Structure
- Shared package `fnd_pkg`:
  - segment pattern constants SEG_0..SEG_9;
  - digit-select constants DIG_ONES..DIG_THOUS;
  - FSM state enum {COLLECT, CONVERT, EMIT};
  - VALUE_W=14.
- Sub-module `fnd_seg_decode`: combinational 8-bit segment pattern → {bad, bcd[3:0]}, instantiated once on the registered data.

## Test plan
- Scan of 1,2,3,4 on thousands..ones, each digit held 100 cycles, `SETTLE_CYC`=16 → exactly one `o_valid` pulse per full scan, `o_value`=1234, `o_err`=0.
- Boundary values: frames of 9999 then 0000 → `o_value`=9999 (14'h270F), then 0; no overflow.
- Glitch rejection: digit pair held 5 cycles, then the true pair held 100 cycles → only the true digit is captured; decoded value is correct.
- Bad pattern: thousands slot shows 8'hFF, then a good frame is scanned → `o_err` pulses once and `o_value` holds its prior value; the next good frame pulses `o_valid`.
- Reset mid-frame: capture 2 digits, pulse reset low → all outputs 0. The next complete 4-digit frame alone produces `o_valid`; the pre-reset digits are not used.
- `FND_DECODE_CHANGE_ONLY_EN`: two identical 1234 frames → one `o_valid` with the macro, two without it.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants and types for the FND scan decoder: segment codes,
// digit-select codes, the frame FSM states and the decoded value width.
package fnd_pkg;

    localparam int VALUE_W = 14;

    // Active-low segment codes {dp,g,f,e,d,c,b,a} with dp forced off.
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;

    localparam logic [3:0] DIG_ONES  = 4'b1110;
    localparam logic [3:0] DIG_TENS  = 4'b1101;
    localparam logic [3:0] DIG_HUNDS = 4'b1011;
    localparam logic [3:0] DIG_THOUS = 4'b0111;

    typedef enum logic [1:0] {
        COLLECT,
        CONVERT,
        EMIT
    } fsm_state_t;

    function automatic logic dig_is_valid(input logic [3:0] dig);
        return (dig == DIG_ONES) || (dig == DIG_TENS) ||
               (dig == DIG_HUNDS) || (dig == DIG_THOUS);
    endfunction

endpackage

// File: rtl/fnd_seg_decode.sv
// Combinational 7-segment pattern to BCD decoder; the decimal point is
// ignored and unknown patterns report bad with digit 0.
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [7:0] seg,
    output logic       bad,
    output logic [3:0] bcd
);

    always_comb begin
        bad = 1'b0;
        bcd = 4'd0;
        case (seg | 8'h80)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Loopback monitor that rebuilds the 4-digit value shown on a multiplexed FND.
// Optional FND_DECODE_CHANGE_ONLY_EN suppresses o_valid for repeated values.
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int SETTLE_CYC = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         fnd_digit,
    input  logic [7:0]         fnd_data,
    output logic [VALUE_W-1:0] o_value,
    output logic               o_valid,
    output logic               o_err
);

    localparam logic [7:0] CAP_AT = 8'(SETTLE_CYC - 1);

    logic [3:0]         digit_p0, digit_p1;
    logic [7:0]         data_p0, data_p1;
    logic [7:0]         stab_cnt;
    logic               pair_same, cap_en;
    logic [3:0]         cap_mask;
    logic               dec_bad;
    logic [3:0]         dec_bcd;
    logic [3:0]         slot_bcd [4];
    logic [3:0]         slot_bad;
    logic [3:0]         col_mask;
    logic [3:0]         snap_bcd [4];
    logic [3:0]         snap_bad;
    logic               frame_take;
    fsm_state_t         state;
    logic [3:0]         frame_bcd [4];
    logic [3:0]         frame_bad;
    logic [VALUE_W-1:0] value_calc;
    logic               bad_any;

    function automatic logic [VALUE_W-1:0] bcd_to_bin(input logic [3:0] d3, input logic [3:0] d2,
                                                      input logic [3:0] d1, input logic [3:0] d0);
        logic [VALUE_W-1:0] thou, hund, tens;
        thou = VALUE_W'(d3) * VALUE_W'(1000);
        hund = VALUE_W'(d2) * VALUE_W'(100);
        tens = VALUE_W'(d1) * VALUE_W'(10);
        return thou + hund + tens + VALUE_W'(d0);
    endfunction

    // Stage p0/p1: input register and the previous registered pair for change detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_p0 <= '0;
            data_p0  <= '0;
            digit_p1 <= '0;
            data_p1  <= '0;
            stab_cnt <= '0;
        end else begin
            digit_p0 <= fnd_digit;
            data_p0  <= fnd_data;
            digit_p1 <= digit_p0;
            data_p1  <= data_p0;
            if (!pair_same)
                stab_cnt <= '0;
            else if (stab_cnt != 8'hFF)
                stab_cnt <= stab_cnt + 8'd1;
        end
    end

    // Capture fires only on the cycle the counter steps onto SETTLE_CYC; saturation blocks repeats.
    assign pair_same = (digit_p0 == digit_p1) && (data_p0 == data_p1);
    assign cap_en    = pair_same && (stab_cnt == CAP_AT) && dig_is_valid(digit_p0);
    assign cap_mask  = cap_en ? ~digit_p0 : 4'b0000;

    fnd_seg_decode u_seg_decode (
        .seg (data_p0),
        .bad (dec_bad),
        .bcd (dec_bcd)
    );

    // Slot contents as they will look after this edge, so a frame can close on its last capture.
    always_comb begin
        snap_bad = slot_bad;
        for (int i = 0; i < 4; i++) begin
            snap_bcd[i] = cap_mask[i] ? dec_bcd : slot_bcd[i];
            snap_bad[i] = cap_mask[i] ? dec_bad : slot_bad[i];
        end
    end

    assign frame_take = (state == COLLECT) && ((col_mask | cap_mask) == 4'b1111);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++)
                slot_bcd[i] <= '0;
            slot_bad <= '0;
            col_mask <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                slot_bcd[i] <= snap_bcd[i];
            slot_bad <= snap_bad;
            col_mask <= frame_take ? 4'b0000 : (col_mask | cap_mask);
        end
    end

    // Frame FSM: snapshot, convert, emit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= COLLECT;
            for (int i = 0; i < 4; i++)
                frame_bcd[i] <= '0;
            frame_bad  <= '0;
            value_calc <= '0;
            bad_any    <= 1'b0;
            o_value    <= '0;
            o_valid    <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            case (state)
                COLLECT: begin
                    if (frame_take) begin
                        for (int i = 0; i < 4; i++)
                            frame_bcd[i] <= snap_bcd[i];
                        frame_bad <= snap_bad;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    value_calc <= bcd_to_bin(frame_bcd[3], frame_bcd[2], frame_bcd[1], frame_bcd[0]);
                    bad_any    <= |frame_bad;
                    state      <= EMIT;
                end
                EMIT: begin
                    if (bad_any) begin
                        o_err <= 1'b1;
                    end else begin
                        o_value <= value_calc;
`ifdef FND_DECODE_CHANGE_ONLY_EN
                        o_valid <= (value_calc != o_value);
`else
                        o_valid <= 1'b1;
`endif
                    end
                    state <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
